// File: rtl/srl_fifo.sv
// First-word fall-through FIFO built on a per-bit shift register (SRL16E style).
// Writes shift the whole array up by one; reads only move the read tap down.
module srl_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic [WIDTH-1:0] dout,
  input  logic             rd_en,
  output logic             empty,
  output logic [4:0]       count
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             rd_acc;
  logic             wr_acc;
  logic [4:0]       count_nxt;
  logic [4:0]       count_m1;
  logic [AW-1:0]    tap;

  assign rd_acc   = rd_en && !empty;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign wr_acc   = wr_en && (!full || rd_acc);
  assign count_m1 = count - 5'd1;
  assign tap      = count_m1[AW-1:0];

  // NOTE: the shift array has no reset so it maps onto SRL primitives;
  // stale contents are never visible because dout is masked while empty.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + 5'd1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - 5'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the pre-edge values of count and the flags together.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      count <= count_nxt;
      empty <= (count_nxt == 5'd0);
      full  <= (count_nxt == DEPTH_C);
    end
  end

  always_comb begin
    dout = '0;
    if (!empty) begin
      dout = mem[tap];
    end
  end

endmodule

// File: doc/srl_fifo.md
SRL_FIFO -- requirements
Module: srl_fifo

Interface
REQ-001 Parameter: WIDTH, 64, data word width in bits.
REQ-002 Parameter: DEPTH, 16, storage entries; legal range 2..16, fits one SRL16E per bit.
REQ-003 Port: CLK  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: din  input  WIDTH  write data.
REQ-006 Port: wr_en  input  1  write request; accepted per REQ-013.
REQ-007 Port: full  output  1  high when occupancy equals DEPTH.
REQ-008 Port: dout  output  WIDTH  oldest stored word (first-word fall-through).
REQ-009 Port: rd_en  input  1  read (pop) request; accepted per REQ-014.
REQ-010 Port: empty  output  1  high when occupancy is 0.
REQ-011 Port: count  output  5  current occupancy, 0..DEPTH.

Function
REQ-012 Storage SHALL be a per-bit shift register of DEPTH entries; an accepted write shifts every entry up one position and loads din at position 0; no other event shifts storage.
REQ-013 Write accepted iff wr_en=1 and (full=0 or accepted read in same cycle).
REQ-014 Read accepted iff rd_en=1 and empty=0.
REQ-015 Read tap SHALL be position count-1; dout SHALL equal the entry at that tap when empty=0, and all-zero when empty=1.
REQ-016 dout SHALL be combinational from storage and count (no read latency); new data written into an empty FIFO SHALL appear on dout the cycle after the write edge.
REQ-017 count update per edge: write only -> +1; read only -> -1; both accepted -> unchanged; neither -> unchanged.
REQ-018 Simultaneous accepted read and write SHALL pop the oldest word and append din, preserving FIFO order (the shift moves the popped word to position count, outside the valid range).
REQ-019 Write with full=1 and no accepted read SHALL be ignored: storage, count, flags unchanged.
REQ-020 Read with empty=1 SHALL be ignored; a concurrent write SHALL still be accepted (count 0 -> 1).
REQ-021 full and empty SHALL be registered, updated on the same edge as count, never both high.
REQ-022 Data order SHALL be strict FIFO; no word duplicated or dropped across any mix of accepted operations.

Reset
REQ-023 rst=1 SHALL immediately (asynchronously) force count=0, empty=1, full=0, dout=0.
REQ-024 Storage contents SHALL NOT be cleared by reset (SRL primitives are not resettable); this SHALL be unobservable because dout is masked while empty.
REQ-025 rst asserted mid-operation SHALL discard all stored words; wr_en/rd_en SHALL be ignored while rst=1; first write after release is accepted on the first edge with rst=0.

Verification
REQ-026 Reset then write 0x11,0x22,0x33 on consecutive cycles -> count 1,2,3; dout 0x11 after first edge and stays 0x11; empty=0.
REQ-027 From REQ-026 state, rd_en for 3 cycles -> dout 0x22, 0x33, then 0 with empty=1, count 0; 4th read ignored, count stays 0.
REQ-028 Fill with 1..16 (DEPTH=16) -> full=1, count=16; write 0xFF with rd_en=0 -> ignored; drain reads 1..16 in order.
REQ-029 Full FIFO, wr_en=rd_en=1 with din=0xAA -> dout advances 1->2, count stays 16, full stays 1; later drain ends with 0xAA.
REQ-030 Empty FIFO, wr_en=rd_en=1 din=0x5A -> read ignored, count=1, dout=0x5A.
REQ-031 Count=5, assert rst between clock edges -> count=0, empty=1, dout=0 before next edge; subsequent write 0x77 -> dout 0x77, count 1.
